// File: rtl/i2c_slave.sv
// I2C target: synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address and moves bytes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on both bus inputs.
module i2c_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [6:0] own_address,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_f, sda_f, scl_p, sda_p;
    logic [3:0]             bit_cnt;
    logic [6:0]             rx_sr;
    logic [6:0]             tx_sr;
    logic                   sda_oe;

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_s, sda_s;
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // A level must be seen in two of the last three samples before it passes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_f    <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[SYNC_STAGES-1];
    assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

    // rx_valid, tx_req and done are one-clk strobes with no back-pressure: rx_data is
    // valid from rx_valid until the next byte, tx_data is captured in the tx_req cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 7'd0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            done     <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                done    <= busy;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        rx_sr <= {rx_sr[5:0], sda_f};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (rx_sr == own_address) begin
                                rw    <= sda_f;
                                busy  <= 1'b1;
                                state <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // sda_oe doubles as the phase flag: low until the 8th fall, high until the 9th.
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            tx_sr   <= tx_data[6:0];
                            sda_oe  <= ~tx_data[7];
                            tx_req  <= 1'b1;
                            bit_cnt <= 4'd1;
                            state   <= READ;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            rx_sr   <= {rx_sr[5:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {rx_sr, sda_f};
                                rx_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WRITE;
                    end
                    READ: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= RD_ACK;
                        end else begin
                            sda_oe  <= ~tx_sr[6];
                            tx_sr   <= {tx_sr[5:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_f) begin
                            busy  <= 1'b0;
                            state <= IGNORE;
                        end else if (scl_fall) begin
                            tx_sr   <= tx_data[6:0];
                            sda_oe  <= ~tx_data[7];
                            tx_req  <= 1'b1;
                            bit_cnt <= 4'd1;
                            state   <= READ;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bus-level master drives transactions while a
// transaction model predicts ACKs, received bytes, read data and strobe counts.
module tb_i2c_slave;

    localparam int QP = 100;

    logic       clk;
    logic       reset_n;
    logic       scl;
    logic       m_sda_oe;
    wire        sda_w;
    logic [6:0] own_address;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw, busy, done;
    logic [2:0] dbg_state;

    assign sda_w = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave dut (
        .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda_w),
        .own_address(own_address), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
        .rw(rw), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_tx_q[$];
    int exp_done = 0, got_done = 0;
    int exp_txreq = 0, got_txreq = 0;
    logic rxv_q = 1'b0, txr_q = 1'b0, done_q = 1'b0;

    // Transaction model state
    localparam int PH_IDLE = 0, PH_ADDR = 1, PH_WRITE = 2, PH_READ = 3, PH_IGNORE = 4;
    int   m_phase = PH_IDLE;
    logic m_busy  = 1'b0;
    logic m_rw    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                chk("rx_valid_width", {31'd0, rxv_q}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got rx_valid with data %0h, expected none", rx_data);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (tx_req) begin
                chk("tx_req_width", {31'd0, txr_q}, 32'd0);
                got_txreq++;
            end
            if (done) begin
                chk("done_width", {31'd0, done_q}, 32'd0);
                got_done++;
            end
        end
        rxv_q  <= rx_valid;
        txr_q  <= tx_req;
        done_q <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic m_start();
        m_sda_oe = 1'b0;
        #QP scl = 1'b1;
        #QP m_sda_oe = 1'b1;
        #QP scl = 1'b0;
        #QP;
        m_busy  = 1'b0;
        m_phase = PH_ADDR;
        exp_tx_q.delete();
    endtask

    task automatic m_stop();
        m_sda_oe = 1'b1;
        #QP scl = 1'b1;
        #QP m_sda_oe = 1'b0;
        #QP;
        if (m_busy) exp_done++;
        m_busy  = 1'b0;
        m_phase = PH_IDLE;
        exp_tx_q.delete();
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        m_sda_oe = ~b;
        #QP scl = 1'b1;
        if (glitch) begin
            #(QP/2) scl = 1'b0;
            #10 scl = 1'b1;
            #(QP/2 - 10);
        end else begin
            #QP;
        end
        if (b) chk("sda_released", {31'd0, sda_w}, 32'd1);
        #QP scl = 1'b0;
        #QP;
    endtask

    task automatic read_bit(output logic b);
        m_sda_oe = 1'b0;
        #QP scl = 1'b1;
        #QP b = sda_w;
        #QP scl = 1'b0;
        #QP;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch);
        logic a;
        logic exp_ack;
        exp_ack = 1'b1;
        if (m_phase == PH_ADDR) begin
            if (d[7:1] == own_address) begin
                exp_ack = 1'b0;
                m_busy  = 1'b1;
                m_rw    = d[0];
                m_phase = d[0] ? PH_READ : PH_WRITE;
            end else begin
                m_phase = PH_IGNORE;
            end
        end else if (m_phase == PH_WRITE) begin
            exp_ack = 1'b0;
            exp_q.push_back(d);
        end
        for (int i = 7; i >= 0; i--) write_bit(d[i], glitch && (i == 5 || i == 2));
        read_bit(a);
        chk("ack", {31'd0, a}, {31'd0, exp_ack});
        if (m_phase == PH_READ && exp_ack == 1'b0) begin
            exp_tx_q.push_back(tx_data);
            exp_txreq++;
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack, 1'b0);
        if (exp_tx_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_unexpected: read %0h with no byte expected", d);
        end else begin
            chk("rd_byte", {24'd0, d}, {24'd0, exp_tx_q.pop_front()});
        end
        if (nack) begin
            m_busy  = 1'b0;
            m_phase = PH_IGNORE;
        end else begin
            exp_tx_q.push_back(tx_data);
            exp_txreq++;
        end
    endtask

    task automatic check_state(input string tag);
        #(20*10);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, m_busy});
        chk({tag, "_rw"}, {31'd0, rw}, {31'd0, m_rw});
        chk({tag, "_done_cnt"}, got_done, exp_done);
        chk({tag, "_txreq_cnt"}, got_txreq, exp_txreq);
        chk({tag, "_rx_missing"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        logic       b;
        reset_n     = 1'b0;
        scl         = 1'b1;
        m_sda_oe    = 1'b0;
        own_address = 7'h50;
        tx_data     = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst_rw", {31'd0, rw}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sda", {31'd0, sda_w}, 32'd1);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write two bytes to 0x50
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h3C, 1'b0);
        write_byte(8'hC3, 1'b0);
        m_stop();
        check_state("t1");
        chk("t1_rx_last", {24'd0, rx_data}, 32'hC3);
        chk("t1_done_lit", got_done, 1);

        // Read two bytes, ACK then NACK
        tx_data = 8'hA5;
        m_start();
        write_byte(8'hA1, 1'b0);
        tx_data = 8'h5A;
        read_byte(1'b0, d);
        chk("t2_byte0_lit", {24'd0, d}, 32'hA5);
        read_byte(1'b1, d);
        chk("t2_byte1_lit", {24'd0, d}, 32'h5A);
        #(20*10);
        chk("t2_busy_after_nack", {31'd0, busy}, 32'd0);
        chk("t2_txreq_lit", got_txreq, 2);
        m_stop();
        check_state("t2");

        // Foreign address 0x51: no ACK, no data
        m_start();
        write_byte(8'hA2, 1'b0);
        write_byte(8'h55, 1'b0);
        m_stop();
        check_state("t3");
        chk("t3_done_lit", got_done, 1);

        // Write then repeated START into a read
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h11, 1'b0);
        tx_data = 8'hF0;
        m_start();
        #(20*10);
        chk("t4_no_done_at_rstart", got_done, 1);
        write_byte(8'hA1, 1'b0);
        #(20*10);
        chk("t4_rw_lit", {31'd0, rw}, 32'd1);
        chk("t4_txreq_lit", got_txreq, 3);
        chk("t4_rx_lit", {24'd0, rx_data}, 32'h11);
        m_stop();
        check_state("t4");
        chk("t4_done_lit", got_done, 2);

        // Reset in the middle of bit 4 of a read byte
        tx_data = 8'h00;
        m_start();
        write_byte(8'hA1, 1'b0);
        for (int i = 0; i < 3; i++) read_bit(b);
        m_sda_oe = 1'b0;
        #QP scl = 1'b1;
        #QP;
        chk("t5_sda_driven_low", {31'd0, sda_w}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t5_sda_released", {31'd0, sda_w}, 32'd1);
        chk("t5_rx_data", {24'd0, rx_data}, 32'h00);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_rw", {31'd0, rw}, 32'd0);
        m_busy  = 1'b0;
        m_rw    = 1'b0;
        m_phase = PH_IDLE;
        exp_tx_q.delete();
        exp_q.delete();
        #(QP-1) reset_n = 1'b1;
        scl = 1'b0;
        #QP;
        m_stop();
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h5E, 1'b0);
        m_stop();
        check_state("t5");
        chk("t5_rx_lit", {24'd0, rx_data}, 32'h5E);
        chk("t5_done_lit", got_done, 3);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // Single-clk low pulses on SCL while high must not disturb the byte
        m_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h96, 1'b1);
        m_stop();
        check_state("t6");
        chk("t6_rx_lit", {24'd0, rx_data}, 32'h96);
`endif

        #(20*10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
